// File: rtl/fifo_rd_gray_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_gray_ctrl
//
// Read-side pointer and flag controller for an asynchronous FIFO. Everything
// runs in the R_CLK domain. The Gray write pointer arriving from the write
// domain passes through a two-flop synchroniser. It is then decoded back to
// binary so the controller can compute occupancy.
//
// Handshake: R_INC is a pop request. A pop is taken on an R_CLK rising edge
// when R_INC=1 and EMPTY=0, so EMPTY acts as the "not ready" side of the
// handshake. R_INC while EMPTY=1 is dropped, with no pointer movement and no
// underflow.
//
// Ports:
//   R_CLK      in   read-domain clock, rising edge
//   R_RST      in   asynchronous active-low reset
//   R_INC      in   pop request
//   WPTR_GRAY  in   Gray write pointer from the write domain (asynchronous)
//   R_ADDR     out  read RAM address (low bits of the binary read pointer)
//   RPTR_GRAY  out  registered Gray read pointer, sent to the write domain
//   EMPTY      out  registered FIFO-empty flag
//   RD_COUNT   out  registered occupancy as seen by the reader
//   GRAY_ERR   out  sticky flag: the synchronised write pointer moved by more
//                   than one bit between consecutive cycles
// -----------------------------------------------------------------------------
module fifo_rd_gray_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  R_INC,
  input  logic [ADDR_WIDTH:0]   WPTR_GRAY,
  output logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [ADDR_WIDTH:0]   RPTR_GRAY,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   RD_COUNT,
  output logic                  GRAY_ERR
);

  localparam int PW = ADDR_WIDTH + 1;

  // Synchroniser stages, plus one history stage used for protocol checking.
  logic [PW-1:0] wq1_q;
  logic [PW-1:0] wq2_q;
  logic [PW-1:0] wq2_prev_q;

  // Read pointer state and registered flags.
  logic [PW-1:0] rbin_q,     rbin_d;
  logic [PW-1:0] rgray_q,    rgray_d;
  logic [PW-1:0] rd_count_q, rd_count_d;
  logic          empty_q,    empty_d;
  logic          gray_err_q, gray_err_d;

  // Combinational helpers.
  logic [PW-1:0] wbin;
  logic [PW-1:0] wq2_diff;
  logic          rd_en;
  logic          multi_bit;

  always_comb begin
    wbin       = '0;
    rd_en      = 1'b0;
    rbin_d     = rbin_q;
    rgray_d    = rgray_q;
    empty_d    = empty_q;
    rd_count_d = rd_count_q;
    wq2_diff   = '0;
    multi_bit  = 1'b0;
    gray_err_d = gray_err_q;

    // Gray-to-binary decode. Each binary bit is the XOR of all Gray bits at
    // or above its position.
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(wq2_q >> i);
    end

    rd_en   = R_INC & ~empty_q;
    rbin_d  = rbin_q + PW'(rd_en);
    rgray_d = rbin_d ^ (rbin_d >> 1);

    // Compare against the already-synchronised write pointer. A write that
    // is still in flight keeps EMPTY asserted a little longer, which is safe.
    empty_d    = (rgray_d == wq2_q);
    rd_count_d = wbin - rbin_d;

    // x & (x-1) clears the lowest set bit. A non-zero result means that two
    // or more bits flipped in one cycle.
    wq2_diff   = wq2_q ^ wq2_prev_q;
    multi_bit  = (wq2_diff & (wq2_diff - PW'(1))) != '0;
    gray_err_d = gray_err_q | multi_bit;
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      wq1_q      <= '0;
      wq2_q      <= '0;
      wq2_prev_q <= '0;
      rbin_q     <= '0;
      rgray_q    <= '0;
      rd_count_q <= '0;
      empty_q    <= 1'b1;
      gray_err_q <= 1'b0;
    end else begin
      // Plain flop-to-flop path between wq1 and wq2. No logic is allowed
      // here, so that the second stage can resolve metastability.
      wq1_q      <= WPTR_GRAY;
      wq2_q      <= wq1_q;
      wq2_prev_q <= wq2_q;
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      rd_count_q <= rd_count_d;
      empty_q    <= empty_d;
      gray_err_q <= gray_err_d;
    end
  end

  assign R_ADDR    = rbin_q[ADDR_WIDTH-1:0];
  assign RPTR_GRAY = rgray_q;
  assign EMPTY     = empty_q;
  assign RD_COUNT  = rd_count_q;
  assign GRAY_ERR  = gray_err_q;

endmodule

// File: tb/tb_fifo_rd_gray_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_gray_ctrl
//
// Bench for the read-side Gray pointer controller (ADDR_WIDTH=3).
//
// The table holds hand-derived per-edge expectations for three scenarios:
// single entry, fill/drain with ignored over-reads, and a Gray protocol
// violation. Hand-written sequences cover reset with random inputs,
// pointer wrap-around and reset asserted mid-operation.
//
// Observed outputs are packed as
//   {R_ADDR[2:0], RPTR_GRAY[3:0], EMPTY, RD_COUNT[3:0], GRAY_ERR}.
// -----------------------------------------------------------------------------
module tb_fifo_rd_gray_ctrl;

  localparam int AW = 3;

  logic          R_CLK;
  logic          R_RST;
  logic          R_INC;
  logic [AW:0]   WPTR_GRAY;
  logic [AW-1:0] R_ADDR;
  logic [AW:0]   RPTR_GRAY;
  logic          EMPTY;
  logic [AW:0]   RD_COUNT;
  logic          GRAY_ERR;

  fifo_rd_gray_ctrl #(.ADDR_WIDTH(AW)) dut (
    .R_CLK     (R_CLK),
    .R_RST     (R_RST),
    .R_INC     (R_INC),
    .WPTR_GRAY (WPTR_GRAY),
    .R_ADDR    (R_ADDR),
    .RPTR_GRAY (RPTR_GRAY),
    .EMPTY     (EMPTY),
    .RD_COUNT  (RD_COUNT),
    .GRAY_ERR  (GRAY_ERR)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    R_CLK = 1'b0;
    forever #5 R_CLK = ~R_CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ------------------------------------------------------------ scoreboard
  logic [12:0] exp_q[$];
  string       lbl_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Gray sequence for 0..15, entered by hand.
  logic [3:0] gray_tab [16];

  typedef struct {
    bit         rst;    // run the reset sequence before this row
    logic       inc;
    logic [3:0] w;
    logic [2:0] addr;
    logic [3:0] rgray;
    logic       empty;
    logic [3:0] cnt;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic inc, logic [3:0] w, logic [2:0] addr,
                              logic [3:0] rgray, logic empty, logic [3:0] cnt, logic err);
    vec_t v;
    v.rst = rst; v.inc = inc; v.w = w; v.addr = addr;
    v.rgray = rgray; v.empty = empty; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  function automatic logic [12:0] pk(logic [2:0] a, logic [3:0] g, logic e,
                                     logic [3:0] c, logic er);
    return {a, g, e, c, er};
  endfunction

  function automatic logic [12:0] obs();
    return {R_ADDR, RPTR_GRAY, EMPTY, RD_COUNT, GRAY_ERR};
  endfunction

  task automatic compare(input string lbl, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got addr=%0d rgray=%b empty=%b cnt=%0d err=%b, expected addr=%0d rgray=%b empty=%b cnt=%0d err=%b",
               lbl, got[12:10], got[9:6], got[5], got[4:1], got[0],
               exp[12:10], exp[9:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check_out();
    logic [12:0] e;
    string       l;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got output with no expectation queued, required one queued entry");
    end else begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      compare(l, obs(), e);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation for the following edge,
  // and check it 1 time unit after that edge.
  task automatic drive(input logic inc, input logic [3:0] w, input logic [12:0] exp,
                       input string lbl);
    R_INC     = inc;
    WPTR_GRAY = w;
    exp_q.push_back(exp);
    lbl_q.push_back(lbl);
    @(posedge R_CLK);
    #1;
    check_out();
  endtask

  // Reset with random inputs. The outputs are checked before any clock edge
  // occurs and again while reset is held across an edge. Reset is released
  // with WPTR_GRAY=0 and R_INC=0.
  task automatic do_reset(input string lbl);
    R_INC     = 1'($urandom_range(0, 1));
    WPTR_GRAY = 4'($urandom_range(0, 15));
    #2;
    R_RST = 1'b0;
    #1;
    compare({lbl, "_async"}, obs(), pk(3'd0, 4'b0000, 1'b1, 4'd0, 1'b0));
    R_INC     = 1'($urandom_range(0, 1));
    WPTR_GRAY = 4'($urandom_range(0, 15));
    @(posedge R_CLK);
    #1;
    compare({lbl, "_held"}, obs(), pk(3'd0, 4'b0000, 1'b1, 4'd0, 1'b0));
    R_INC     = 1'b0;
    WPTR_GRAY = 4'b0000;
    @(posedge R_CLK);
    #1;
    R_RST = 1'b1;
  endtask

  // ------------------------------------------------------------------ test
  initial begin
    R_RST     = 1'b1;
    R_INC     = 1'b0;
    WPTR_GRAY = 4'b0000;

    gray_tab[0]  = 4'b0000; gray_tab[1]  = 4'b0001; gray_tab[2]  = 4'b0011; gray_tab[3]  = 4'b0010;
    gray_tab[4]  = 4'b0110; gray_tab[5]  = 4'b0111; gray_tab[6]  = 4'b0101; gray_tab[7]  = 4'b0100;
    gray_tab[8]  = 4'b1100; gray_tab[9]  = 4'b1101; gray_tab[10] = 4'b1111; gray_tab[11] = 4'b1110;
    gray_tab[12] = 4'b1010; gray_tab[13] = 4'b1011; gray_tab[14] = 4'b1001; gray_tab[15] = 4'b1000;

    // Single entry: EMPTY falls 3 edges after the write-pointer step. A
    // pop then empties at once, and the following R_INC is ignored.
    //               rst inc  w        addr rgray    emp cnt err
    vecs.push_back(mk(1, 0, 4'b0001, 3'd0, 4'b0000, 1, 4'd0, 0));
    vecs.push_back(mk(0, 0, 4'b0001, 3'd0, 4'b0000, 1, 4'd0, 0));
    vecs.push_back(mk(0, 0, 4'b0001, 3'd0, 4'b0000, 0, 4'd1, 0));
    vecs.push_back(mk(0, 1, 4'b0001, 3'd1, 4'b0001, 1, 4'd0, 0));
    vecs.push_back(mk(0, 1, 4'b0001, 3'd1, 4'b0001, 1, 4'd0, 0));
    // Fill to 8 and drain. The last two reads are ignored.
    vecs.push_back(mk(1, 0, 4'b0001, 3'd0, 4'b0000, 1, 4'd0, 0));
    vecs.push_back(mk(0, 0, 4'b0011, 3'd0, 4'b0000, 1, 4'd0, 0));
    vecs.push_back(mk(0, 0, 4'b0010, 3'd0, 4'b0000, 0, 4'd1, 0));
    vecs.push_back(mk(0, 0, 4'b0110, 3'd0, 4'b0000, 0, 4'd2, 0));
    vecs.push_back(mk(0, 0, 4'b0111, 3'd0, 4'b0000, 0, 4'd3, 0));
    vecs.push_back(mk(0, 0, 4'b0101, 3'd0, 4'b0000, 0, 4'd4, 0));
    vecs.push_back(mk(0, 0, 4'b0100, 3'd0, 4'b0000, 0, 4'd5, 0));
    vecs.push_back(mk(0, 0, 4'b1100, 3'd0, 4'b0000, 0, 4'd6, 0));
    vecs.push_back(mk(0, 0, 4'b1100, 3'd0, 4'b0000, 0, 4'd7, 0));
    vecs.push_back(mk(0, 0, 4'b1100, 3'd0, 4'b0000, 0, 4'd8, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd1, 4'b0001, 0, 4'd7, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd2, 4'b0011, 0, 4'd6, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd3, 4'b0010, 0, 4'd5, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd4, 4'b0110, 0, 4'd4, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd5, 4'b0111, 0, 4'd3, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd6, 4'b0101, 0, 4'd2, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd7, 4'b0100, 0, 4'd1, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd0, 4'b1100, 1, 4'd0, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd0, 4'b1100, 1, 4'd0, 0));
    vecs.push_back(mk(0, 1, 4'b1100, 3'd0, 4'b1100, 1, 4'd0, 0));
    // Gray violation 0000->0011: GRAY_ERR rises 3 edges later and then
    // sticks through legal pops and a legal write step.
    vecs.push_back(mk(1, 0, 4'b0011, 3'd0, 4'b0000, 1, 4'd0, 0));
    vecs.push_back(mk(0, 0, 4'b0011, 3'd0, 4'b0000, 1, 4'd0, 0));
    vecs.push_back(mk(0, 0, 4'b0011, 3'd0, 4'b0000, 0, 4'd2, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 3'd1, 4'b0001, 0, 4'd1, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 3'd2, 4'b0011, 1, 4'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0010, 3'd2, 4'b0011, 1, 4'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0010, 3'd2, 4'b0011, 1, 4'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0010, 3'd2, 4'b0011, 0, 4'd1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset($sformatf("reset_before_row%0d", i));
      drive(vecs[i].inc, vecs[i].w,
            pk(vecs[i].addr, vecs[i].rgray, vecs[i].empty, vecs[i].cnt, vecs[i].err),
            $sformatf("tbl_row%0d", i));
    end

    // Wrap-around: 16 write-step/pop pairs. Each pair takes 4 edges: the
    // write step, two edges of synchroniser latency, then the pop.
    do_reset("reset_wrap");
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] w_now;
      logic [3:0] g_prev;
      logic [3:0] g_now;
      logic [2:0] a_prev;
      logic [2:0] a_now;
      w_now  = gray_tab[i % 16];
      g_prev = gray_tab[(i - 1) % 16];
      g_now  = gray_tab[i % 16];
      a_prev = 3'((i - 1) % 8);
      a_now  = 3'(i % 8);
      drive(1'b0, w_now, pk(a_prev, g_prev, 1'b1, 4'd0, 1'b0), $sformatf("wrap%0d_a", i));
      drive(1'b0, w_now, pk(a_prev, g_prev, 1'b1, 4'd0, 1'b0), $sformatf("wrap%0d_b", i));
      drive(1'b0, w_now, pk(a_prev, g_prev, 1'b0, 4'd1, 1'b0), $sformatf("wrap%0d_c", i));
      drive(1'b1, w_now, pk(a_now,  g_now,  1'b1, 4'd0, 1'b0), $sformatf("wrap%0d_pop", i));
    end

    // Reset mid-operation: fill to 5, then assert reset between edges
    // while R_INC=1.
    do_reset("reset_mid_pre");
    for (int n = 1; n <= 7; n++) begin
      logic [3:0] c;
      c = (n >= 3) ? 4'(n - 2) : 4'd0;
      drive(1'b0, gray_tab[(n > 5) ? 5 : n], pk(3'd0, 4'b0000, (n < 3), c, 1'b0),
            $sformatf("mid_fill%0d", n));
    end
    R_INC = 1'b1;
    #2;
    R_RST = 1'b0;
    #1;
    compare("mid_reset_async", obs(), pk(3'd0, 4'b0000, 1'b1, 4'd0, 1'b0));
    WPTR_GRAY = 4'b0000;
    @(posedge R_CLK);
    #1;
    R_RST = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 4'b0000, pk(3'd0, 4'b0000, 1'b1, 4'd0, 1'b0), $sformatf("mid_after%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
